c1_image_loader: RTL and testbench
==================================

# c1_image_loader

Upstream feeder for the C1 receptive-field selector. Accepts a stream of FP16 input pixels over a valid/ready handshake and packs them into the flat `image` vector the selector consumes. Once a full frame is held, it sequences the selector's `row` index from 0 to H-Size, one output row per downstream handshake. It then returns to loading the next frame.

## Interface
Parameters:
- DATA_WIDTH, 16, bits per pixel (FP16 word)
- Depth, 1, input channels
- Size, 5, filter size
- H, 32, image height
- W, 32, image width

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- in_valid  in  1  in_data holds a pixel
- in_ready  out  1  loader accepts a pixel this cycle
- in_data  in  DATA_WIDTH  pixel, raster order: channel, then row, then column
- image  out  Depth*H*W*DATA_WIDTH  packed frame; pixel k at [k*DATA_WIDTH +: DATA_WIDTH]
- row  out  6  selector row index
- column  out  6  selector column index; constant 0
- rf_valid  out  1  image/row form a valid selector request
- rf_ready  in  1  downstream consumed the current row
- frame_done  out  1  one-cycle pulse after the last row is consumed

## Operation
- The block has two states: LOAD and SCAN. Reset enters LOAD with the pixel counter `pix` set to 0.
- Constants: N = Depth*H*W and LAST_ROW = H-Size (27 at defaults). `pix` is $clog2(N+1) bits wide.
- **LOAD:**
  - in_ready = 1 and rf_valid = 0.
  - On an edge where in_valid && in_ready: image[pix*DATA_WIDTH +: DATA_WIDTH] <= in_data, and pix <= pix+1.
  - The edge that accepts pixel N-1 moves the block to SCAN, clears pix, and sets row to 0.
  - in_valid gaps are allowed. The counter holds while in_valid = 0.
  - Pixels of a new frame overwrite the previous frame in place. image is not cleared between frames.
- **SCAN:**
  - in_ready = 0 and rf_valid = 1. in_valid and in_data are ignored, and image is frozen.
  - On an edge where rf_valid && rf_ready:
    - If row < LAST_ROW: row <= row+1.
    - If row == LAST_ROW: go to LOAD, set row <= 0 and rf_valid <= 0, pulse frame_done for one cycle, and set in_ready <= 1.
  - While rf_ready = 0, row and image hold indefinitely.
- column is always 0. The selector covers all W-Size+1 columns of a row in parallel.
- row never exceeds LAST_ROW. Values above LAST_ROW are unreachable.

## Timing
- All outputs are registered.
- Reset values: image = 0, row = 0, column = 0, rf_valid = 0, in_ready = 0, frame_done = 0.
- in_ready goes to 1 at the first rising edge after reset deasserts.
- Load throughput is one pixel per cycle. A full frame needs N accepting edges (1024 at defaults).
- Pixel N-1 accepted at edge t:
  - From t onward, in_ready = 0, rf_valid = 1, and row = 0.
  - image includes pixel N-1 from t onward.
- Row advance: a handshake at edge t makes row+1 visible after t. Throughput is one row per cycle when rf_ready stays high.
- Last-row handshake at edge t:
  - frame_done = 1 for the cycle after t only.
  - in_ready = 1 and rf_valid = 0 from t onward.
  - A pixel may be accepted at edge t+1.
- Minimum frame period is N + (LAST_ROW+1) cycles (1052 at defaults).
- in_ready and rf_valid are never both high.
- Reset mid-operation from any state, asserted at any time: immediately restores all reset values and pix = 0. The partial frame is discarded.

## Test plan
- **Reset:** assert reset mid-cycle. Required response: all outputs take their reset values immediately. After deassert, in_ready = 1 after the first edge and rf_valid = 0.
- **Ramp load:** stream in_data = k for k = 0..1023 with in_valid held high. Required response:
  - image word k == 16'h(k) for every k.
  - rf_valid rises on the edge accepting k = 1023, with row = 0 and column = 0.
- **Gapped input:** in_valid toggles 1,0,0,1 while values 0x3C00 + k are streamed. Required response:
  - Exactly 1024 pixels are captured and none are duplicated.
  - Words at index 0, 511 and 1023 equal 0x3C00, 0x3DFF and 0x3FFF.
  - Pixels presented during SCAN leave image unchanged.
- **Row scan with backpressure:**
  - rf_ready low for 5 cycles at row 9: row stays 9.
  - Then rf_ready high: rows 10..27 follow on consecutive cycles.
  - frame_done pulses once, and row returns to 0 with in_ready = 1.
- **Back-to-back frames:** load frame A (all 0x1111), scan, then load frame B (all 0x2222). Required response: during B's SCAN every image word is 0x2222, and frame_done pulses exactly twice in total.
- **Reset mid-load:** reset after 300 pixels, then load a full frame of ramp values. Required response: rf_valid rises only after 1024 post-reset pixels, and image matches the ramp exactly.

Source files
------------

// File: rtl/c1_image_loader.sv
// Packs a raster stream of FP16 pixels into a flat frame vector, then steps the
// C1 receptive-field selector through rows 0..H-Size, one row per handshake.
module c1_image_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int Depth      = 1,
  parameter int Size       = 5,
  parameter int H          = 32,
  parameter int W          = 32
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_WIDTH-1:0]             in_data,
  output logic [Depth*H*W*DATA_WIDTH-1:0]   image,
  output logic [5:0]                        row,
  output logic [5:0]                        column,
  output logic                              rf_valid,
  input  logic                              rf_ready,
  output logic                              frame_done
);

  localparam int                N        = Depth * H * W;
  localparam int                PIX_W    = $clog2(N + 1);
  localparam logic [PIX_W-1:0]  PIX_LAST = PIX_W'(N - 1);
  localparam logic [5:0]        LAST_ROW = 6'(H - Size);

  typedef enum logic [0:0] {
    ST_LOAD = 1'b0,
    ST_SCAN = 1'b1
  } state_e;

  state_e                            state_q;
  logic [PIX_W-1:0]                  pix_q;
  logic [Depth*H*W*DATA_WIDTH-1:0]   image_q;
  logic [5:0]                        row_q;
  logic                              rf_valid_q;
  logic                              in_ready_q;
  logic                              frame_done_q;

  // Load/scan sequencer; every output is a register updated here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_LOAD;
      pix_q        <= '0;
      image_q      <= '0;
      row_q        <= 6'd0;
      rf_valid_q   <= 1'b0;
      in_ready_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        ST_LOAD: begin
          rf_valid_q <= 1'b0;
          if (in_valid && in_ready_q) begin
            image_q[pix_q*DATA_WIDTH +: DATA_WIDTH] <= in_data;
            if (pix_q == PIX_LAST) begin
              state_q    <= ST_SCAN;
              pix_q      <= '0;
              row_q      <= 6'd0;
              in_ready_q <= 1'b0;
              rf_valid_q <= 1'b1;
            end else begin
              pix_q      <= pix_q + PIX_W'(1);
              in_ready_q <= 1'b1;
            end
          end else begin
            // First edge after reset lands here and opens the input.
            in_ready_q <= 1'b1;
          end
        end
        ST_SCAN: begin
          in_ready_q <= 1'b0;
          if (rf_ready) begin
            if (row_q == LAST_ROW) begin
              state_q      <= ST_LOAD;
              row_q        <= 6'd0;
              rf_valid_q   <= 1'b0;
              in_ready_q   <= 1'b1;
              frame_done_q <= 1'b1;
            end else begin
              row_q      <= row_q + 6'd1;
              rf_valid_q <= 1'b1;
            end
          end else begin
            rf_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= ST_LOAD;
          pix_q      <= '0;
          row_q      <= 6'd0;
          rf_valid_q <= 1'b0;
          in_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign rf_valid   = rf_valid_q;
  assign image      = image_q;
  assign row        = row_q;
  assign column     = 6'd0;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_c1_image_loader.sv
// Randomized self-checking bench for c1_image_loader against a frame-level
// reference model (pixel array, accepted-pixel count, current row).
module tb_c1_image_loader;

  localparam int DW       = 16;
  localparam int N        = 1024;
  localparam int LAST_ROW = 27;

  logic            clk;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_data;
  logic [N*DW-1:0] image;
  logic [5:0]      row;
  logic [5:0]      column;
  logic            rf_valid;
  logic            rf_ready;
  logic            frame_done;

  c1_image_loader dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .image      (image),
    .row        (row),
    .column     (column),
    .rf_valid   (rf_valid),
    .rf_ready   (rf_ready),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // reference model state
  logic [DW-1:0] m_img [N];
  bit  m_load;
  int  m_cnt;
  int  m_row;
  bit  m_rdy;
  bit  m_vld;
  bit  m_done;
  int  m_done_cnt = 0;
  int  obs_done   = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_load = 1'b1;
    m_cnt  = 0;
    m_row  = 0;
    m_rdy  = 1'b0;
    m_vld  = 1'b0;
    m_done = 1'b0;
    for (int k = 0; k < N; k++) m_img[k] = '0;
  endtask

  // One clock of the frame-level behaviour, using the inputs present at the edge.
  task automatic model_step();
    m_done = 1'b0;
    if (m_load) begin
      if (in_valid && m_rdy) begin
        m_img[m_cnt] = in_data;
        m_cnt++;
        if (m_cnt == N) begin
          m_load = 1'b0;
          m_cnt  = 0;
          m_row  = 0;
        end
      end
      m_rdy = m_load;
      m_vld = !m_load;
    end else if (rf_ready) begin
      if (m_row == LAST_ROW) begin
        m_load = 1'b1;
        m_row  = 0;
        m_rdy  = 1'b1;
        m_vld  = 1'b0;
        m_done = 1'b1;
        m_done_cnt++;
      end else begin
        m_row++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk_eq("in_ready",   32'(in_ready),   32'(m_rdy));
    chk_eq("rf_valid",   32'(rf_valid),   32'(m_vld));
    chk_eq("row",        32'(row),        32'(m_row));
    chk_eq("frame_done", 32'(frame_done), 32'(m_done));
    chk_eq("column",     32'(column),     32'(0));
    chk_eq("excl",       32'(in_ready & rf_valid), 32'(0));
    if (frame_done) obs_done++;
  endtask

  task automatic check_image(input string tag);
    for (int k = 0; k < N; k++)
      chk_eq(tag, 32'(image[k*DW +: DW]), 32'(m_img[k]));
  endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock.
  task automatic do_reset();
    #2;
    reset    = 1'b1;
    in_valid = 1'b0;
    rf_ready = 1'b0;
    #1;
    model_reset();
    chk_eq("rst_in_ready",   32'(in_ready),   32'(0));
    chk_eq("rst_rf_valid",   32'(rf_valid),   32'(0));
    chk_eq("rst_row",        32'(row),        32'(0));
    chk_eq("rst_column",     32'(column),     32'(0));
    chk_eq("rst_frame_done", 32'(frame_done), 32'(0));
    chk_eq("rst_image",      32'(|image),     32'(0));
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk_eq("post_rst_ready", 32'(in_ready), 32'(1));
  endtask

  // dmode: 0 ramp base+idx, 1 constant base, 2 random; gmode: 0 dense, 1 1-0-0-1, 2 random
  task automatic load_frame(input int dmode, input logic [DW-1:0] base, input int gmode, input int stop_at);
    for (int c = 0; c < 6000 && m_load && m_cnt != stop_at; c++) begin
      case (gmode)
        0:       in_valid = 1'b1;
        1:       in_valid = ((c % 4) == 0) || ((c % 4) == 3);
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      if (in_valid) begin
        case (dmode)
          0:       in_data = base + DW'(m_cnt);
          1:       in_data = base;
          default: in_data = DW'($urandom);
        endcase
      end else begin
        in_data = DW'($urandom);
      end
      rf_ready = 1'($urandom_range(0, 1));
      tick();
    end
    in_valid = 1'b0;
    if (stop_at < 0) begin
      chk_eq("load_end_vld", 32'(rf_valid), 32'(1));
      chk_eq("load_end_row", 32'(row),      32'(0));
    end
  endtask

  // bmode: 0 always ready, 1 stall 5 cycles at row 9, 2 random
  task automatic scan_frame(input int bmode);
    int stall = 0;
    for (int c = 0; c < 2000 && !m_load; c++) begin
      case (bmode)
        0: rf_ready = 1'b1;
        1: begin
          if (m_row == 9 && stall < 5) begin
            rf_ready = 1'b0;
            stall++;
          end else begin
            rf_ready = 1'b1;
          end
        end
        default: rf_ready = 1'($urandom_range(0, 1));
      endcase
      in_valid = 1'($urandom_range(0, 1));
      in_data  = DW'($urandom);
      tick();
      if (bmode == 1 && stall == 5 && !rf_ready) chk_eq("bp_row9", 32'(row), 32'(9));
    end
    rf_ready = 1'b0;
    in_valid = 1'b0;
    chk_eq("scan_end_rdy", 32'(in_ready), 32'(1));
    chk_eq("scan_end_vld", 32'(rf_valid), 32'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0;
    reset    = 1'b1;
    in_valid = 1'b0;
    rf_ready = 1'b0;
    in_data  = '0;
    #7;
    do_reset();

    // ramp load, then scan with backpressure at row 9
    load_frame(0, 16'h0000, 0, -1);
    check_image("ramp_img");
    chk_eq("ramp_w1023", 32'(image[1023*DW +: DW]), 32'h3FF);
    scan_frame(1);
    check_image("scan_img");

    // gapped load, junk presented during scan
    load_frame(0, 16'h3C00, 1, -1);
    chk_eq("gap_w0",    32'(image[0*DW +: DW]),    32'h3C00);
    chk_eq("gap_w511",  32'(image[511*DW +: DW]),  32'h3DFF);
    chk_eq("gap_w1023", 32'(image[1023*DW +: DW]), 32'h3FFF);
    scan_frame(0);
    check_image("gap_scan_img");

    // back-to-back frames
    d0 = obs_done;
    load_frame(1, 16'h1111, 0, -1);
    check_image("frameA_img");
    scan_frame(2);
    load_frame(1, 16'h2222, 0, -1);
    check_image("frameB_img");
    chk_eq("frameB_w700", 32'(image[700*DW +: DW]), 32'h2222);
    scan_frame(0);
    chk_eq("b2b_done", 32'(obs_done - d0), 32'(2));

    // reset after 300 pixels, then full ramp
    load_frame(0, 16'h5000, 0, 300);
    chk_eq("part_vld", 32'(rf_valid), 32'(0));
    do_reset();
    load_frame(0, 16'h0000, 0, -1);
    check_image("rst_ramp_img");
    scan_frame(2);

    // fully random frames
    for (int f = 0; f < 2; f++) begin
      load_frame(2, 16'h0000, 2, -1);
      check_image("rnd_img");
      scan_frame(2);
      check_image("rnd_scan_img");
    end

    chk_eq("done_total", 32'(obs_done), 32'(m_done_cnt));
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
